ring_delay: RTL

RING_DELAY -- requirements
Module: ring_delay

---
 rtl/ring_delay.sv | 81 ++++++++
 1 files changed

// File: rtl/ring_delay.sv
// Programmable sample delay line: a circular buffer plus a FILL/RUN tracker that
// marks outputs as valid once the buffer holds d samples written since the last restart.
module ring_delay #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 1024,
  parameter int DW        = $clog2(MAX_DELAY+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW:0]   MAXD = (DW+1)'(MAX_DELAY);
  localparam logic [AW-1:0] WP_LAST = AW'(MAX_DELAY-1);

  typedef enum logic {FILL, RUN} state_t;

  logic [WIDTH-1:0] mem [MAX_DELAY];
  logic [AW-1:0]    wp;
  logic [DW-1:0]    cnt, d_q, d, cnt_nx;
  state_t           state;
  logic [DW:0]      rd_sum, rd_wrap;
  logic [AW-1:0]    rd_addr;

  // Effective delay: clamp into 1..MAX_DELAY.
  always_comb begin
    d = delay;
    if (delay == '0)                 d = DW'(1);
    else if ({1'b0, delay} > MAXD)   d = MAXD[DW-1:0];
  end

  // Read address (wp - d + 1) mod MAX_DELAY, kept non-negative by biasing with MAX_DELAY.
  always_comb begin
    rd_sum  = (DW+1)'(wp) + MAXD - {1'b0, d} + (DW+1)'(1);
    rd_wrap = (rd_sum >= MAXD) ? rd_sum - MAXD : rd_sum;
    rd_addr = rd_wrap[AW-1:0];
    cnt_nx  = cnt + DW'(1);
  end

  // Memory kept out of the reset path so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && ce) mem[wp] <= in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
      wp    <= '0;
      cnt   <= '0;
      d_q   <= '0;
      state <= FILL;
    end else if (ce) begin
      wp  <= (wp == WP_LAST) ? '0 : wp + AW'(1);
      out <= (d == DW'(1)) ? in : mem[rd_addr];
      if (d != d_q) begin
        d_q <= d;
        cnt <= DW'(1);
        if (d == DW'(1)) begin
          state <= RUN;
          valid <= 1'b1;
        end else begin
          state <= FILL;
          valid <= 1'b0;
        end
      end else if (state == FILL) begin
        cnt <= cnt_nx;
        if (cnt_nx == d) begin
          state <= RUN;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule
